// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder step per clock, LSB first.
// Optional signed-overflow flag enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             carry;
  logic             sum;
  logic             carry_n;
  logic             last;

  assign last    = (count == CW'(WIDTH-1));
  assign sum     = op_a[0] ^ op_b[0] ^ carry;
  assign carry_n = (op_a[0] & op_b[0]) |
                   (op_a[0] & carry) |
                   (op_b[0] & carry);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: start is only honoured outside SHIFT
  always_comb begin
    state_n = state;
    case (state)
      IDLE,
      DONE:    state_n = start ? SHIFT : IDLE;
      SHIFT:   if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Operand load, serial shift and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
      S     <= '0;
      c_out <= 1'b0;
    end else begin
      busy <= (state_n == SHIFT);
      done <= (state_n == DONE);
      if (state != SHIFT && start) begin
        op_a  <= A;
        op_b  <= sub ? ~B : B;
        carry <= sub;
        acc   <= '0;
        count <= '0;
      end else if (state == SHIFT) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        acc   <= {sum, acc[WIDTH-1:1]};
        carry <= carry_n;
        count <= count + CW'(1);
        if (last) begin
          S     <= {sum, acc[WIDTH-1:1]};
          c_out <= carry_n;
        end
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Overflow: carry into MSB differs from carry out of MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      ovf <= 1'b0;
    else if (state == SHIFT && last) ovf <= carry ^ carry_n;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
